// File: rtl/adc_scan_pkg.sv
// Shared types and defaults for the ADC scan sequencer.
//   state_t        : scan controller states
//   chw()          : channel-select width for a given channel count
//   Def*           : default timing / sizing constants
package adc_scan_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StSettle,
        StConvert,
        StStore,
        StDone,
        StWaitPeriod
    } state_t;

    localparam int unsigned DefNumCh       = 4;
    localparam int unsigned DefDataW       = 16;
    localparam int unsigned DefSettleCyc   = 1000;
    localparam int unsigned DefScanPeriod  = 1_000_000;
    localparam int unsigned DefConvTimeout = 2_000_000;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned chw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_result_regfile.sv
// Per-channel result store for the scan sequencer.
// One write port, one registered read port (1-cycle latency). A read of the
// channel being written in the same cycle returns the new value.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   wr_en/wr_ch/wr_data  write strobe, channel, result
//   rd_ch                read address
//   rd_data/rd_valid     registered result and written-since-reset flag
module adc_result_regfile
    import adc_scan_pkg::*;
#(
    parameter  int unsigned NUM_CH = DefNumCh,
    parameter  int unsigned DATA_W = DefDataW,
    localparam int unsigned CHW    = chw(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CHW-1:0]    wr_ch,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [CHW-1:0]    rd_ch,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    logic [DATA_W-1:0] mem_q [NUM_CH];
    logic [NUM_CH-1:0] vld_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mem_q[i] <= '0;
            end
            vld_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ch] <= wr_data;
                vld_q[wr_ch] <= 1'b1;
            end
            // Write-through so a same-cycle read sees the fresh result.
            if (wr_en && (wr_ch == rd_ch)) begin
                rd_data_q  <= wr_data;
                rd_valid_q <= 1'b1;
            end else if (32'(rd_ch) < NUM_CH) begin
                rd_data_q  <= mem_q[rd_ch];
                rd_valid_q <= vld_q[rd_ch];
            end else begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/adc_scan_sequencer.sv
// Multi-channel scan controller for the PWM SAR ADC. Steps an analog mux
// through the enabled channels, waits a settle time, requests a conversion,
// stores the result per channel and repeats at a fixed period when enabled.
// Optional build macro: OVERSAMPLE_AVG_EN -- 4 back-to-back conversions per
// channel, stored value is their truncated average.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   enable          continuous scanning; low stops after the current channel
//   single_shot     one-cycle pulse, one full scan (only from idle)
//   ch_mask         channel enable mask, latched at scan start
//   mux_sel         analog mux select
//   adc_start       one-cycle conversion request
//   adc_done        one-cycle conversion complete, adc_data valid
//   adc_data        conversion result
//   rd_ch           result read address
//   rd_data         registered result for rd_ch
//   rd_valid        rd_ch written since reset
//   busy            scan in progress
//   scan_done       one-cycle pulse after the last channel is stored
//   timeout_err     sticky conversion timeout flag
//   err_clr         clear timeout_err (a simultaneous new timeout wins)
module adc_scan_sequencer
    import adc_scan_pkg::*;
#(
    parameter  int unsigned NUM_CH       = DefNumCh,
    parameter  int unsigned DATA_W       = DefDataW,
    parameter  int unsigned SETTLE_CYC   = DefSettleCyc,
    parameter  int unsigned SCAN_PERIOD  = DefScanPeriod,
    parameter  int unsigned CONV_TIMEOUT = DefConvTimeout,
    localparam int unsigned CHW          = chw(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              single_shot,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [CHW-1:0]    mux_sel,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [CHW-1:0]    rd_ch,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              scan_done,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TW = $clog2(CONV_TIMEOUT + 1);
    localparam int unsigned PW = $clog2(SCAN_PERIOD + 1);

    localparam logic [SW-1:0] SettleLoad = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] ConvLoad   = TW'(CONV_TIMEOUT - 1);
    localparam logic [PW-1:0] PeriodLoad = PW'(SCAN_PERIOD - 1);

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] act_mask_q, act_mask_d;
    logic [CHW-1:0]    mux_sel_q, mux_sel_d;
    logic [SW-1:0]     settle_ctr_q, settle_ctr_d;
    logic [TW-1:0]     conv_ctr_q, conv_ctr_d;
    logic [PW-1:0]     period_ctr_q, period_ctr_d;
    logic              adc_start_q, adc_start_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              skip_q, skip_d;      // current channel timed out, do not store
    logic              cont_q, cont_d;      // scan was started in continuous mode
    logic              stop_q, stop_d;      // enable fell during a continuous scan
    logic              timeout_err_q, timeout_err_d;

`ifdef OVERSAMPLE_AVG_EN
    localparam int unsigned SumW = DATA_W + 2;
    logic [1:0]        os_cnt_q, os_cnt_d;
    logic [SumW-1:0]   sum_q, sum_d;
`endif

    logic              err_set;
    logic              wr_en;
    logic              start_scan;
    logic [NUM_CH-1:0] mask_left;
    logic [CHW-1:0]    next_ch;

    // Serviced bits are cleared from act_mask, so the lowest remaining bit is
    // always the next channel at or above the current index.
    always_comb begin
        next_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (act_mask_q[i]) begin
                next_ch = CHW'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        act_mask_d    = act_mask_q;
        mux_sel_d     = mux_sel_q;
        settle_ctr_d  = settle_ctr_q;
        conv_ctr_d    = conv_ctr_q;
        period_ctr_d  = (period_ctr_q != '0) ? period_ctr_q - PW'(1) : period_ctr_q;
        adc_start_d   = 1'b0;
        result_d      = result_q;
        skip_d        = skip_q;
        cont_d        = cont_q;
        stop_d        = stop_q | (cont_q & ~enable);
        err_set       = 1'b0;
        wr_en         = 1'b0;
        start_scan    = 1'b0;
        mask_left     = act_mask_q & ~(NUM_CH'(1) << mux_sel_q);
`ifdef OVERSAMPLE_AVG_EN
        os_cnt_d      = os_cnt_q;
        sum_d         = sum_q;
`endif

        unique case (state_q)
            StIdle: begin
                if ((enable || single_shot) && (ch_mask != '0)) begin
                    start_scan = 1'b1;
                end
            end
            StSelect: begin
                mux_sel_d    = next_ch;
                settle_ctr_d = SettleLoad;
                state_d      = StSettle;
            end
            StSettle: begin
                if (settle_ctr_q == '0) begin
                    state_d     = StConvert;
                    adc_start_d = 1'b1;
                    conv_ctr_d  = ConvLoad;
                    skip_d      = 1'b0;
`ifdef OVERSAMPLE_AVG_EN
                    os_cnt_d    = '0;
                    sum_d       = '0;
`endif
                end else begin
                    settle_ctr_d = settle_ctr_q - SW'(1);
                end
            end
            StConvert: begin
                if (adc_done) begin
`ifdef OVERSAMPLE_AVG_EN
                    sum_d = sum_q + SumW'(adc_data);
                    if (os_cnt_q == 2'd3) begin
                        result_d = sum_d[SumW-1:2];
                        state_d  = StStore;
                    end else begin
                        // Next conversion follows immediately, no re-settle.
                        os_cnt_d    = os_cnt_q + 2'd1;
                        adc_start_d = 1'b1;
                        conv_ctr_d  = ConvLoad;
                    end
`else
                    result_d = adc_data;
                    state_d  = StStore;
`endif
                end else if (conv_ctr_q == '0) begin
                    err_set = 1'b1;
                    skip_d  = 1'b1;
                    state_d = StStore;
                end else begin
                    conv_ctr_d = conv_ctr_q - TW'(1);
                end
            end
            StStore: begin
                wr_en      = ~skip_q;
                act_mask_d = mask_left;
                state_d    = ((mask_left == '0) || stop_d) ? StDone : StSelect;
            end
            StDone: begin
                if (enable) begin
                    // Overrun scans restart at once; missed periods are not queued.
                    if ((period_ctr_q == '0) && (ch_mask != '0)) begin
                        start_scan = 1'b1;
                    end else begin
                        state_d = StWaitPeriod;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWaitPeriod: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if ((period_ctr_q == '0) && (ch_mask != '0)) begin
                    start_scan = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start_scan) begin
            state_d      = StSelect;
            act_mask_d   = ch_mask;
            period_ctr_d = PeriodLoad;
            cont_d       = enable;
            stop_d       = 1'b0;
        end

        timeout_err_d = err_set | (timeout_err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            act_mask_q    <= '0;
            mux_sel_q     <= '0;
            settle_ctr_q  <= '0;
            conv_ctr_q    <= '0;
            period_ctr_q  <= '0;
            adc_start_q   <= 1'b0;
            result_q      <= '0;
            skip_q        <= 1'b0;
            cont_q        <= 1'b0;
            stop_q        <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef OVERSAMPLE_AVG_EN
            os_cnt_q      <= '0;
            sum_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            act_mask_q    <= act_mask_d;
            mux_sel_q     <= mux_sel_d;
            settle_ctr_q  <= settle_ctr_d;
            conv_ctr_q    <= conv_ctr_d;
            period_ctr_q  <= period_ctr_d;
            adc_start_q   <= adc_start_d;
            result_q      <= result_d;
            skip_q        <= skip_d;
            cont_q        <= cont_d;
            stop_q        <= stop_d;
            timeout_err_q <= timeout_err_d;
`ifdef OVERSAMPLE_AVG_EN
            os_cnt_q      <= os_cnt_d;
            sum_q         <= sum_d;
`endif
        end
    end

    adc_result_regfile #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_ch    (mux_sel_q),
        .wr_data  (result_q),
        .rd_ch    (rd_ch),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    assign mux_sel     = mux_sel_q;
    assign adc_start   = adc_start_q;
    assign busy        = (state_q != StIdle) && (state_q != StWaitPeriod);
    assign scan_done   = (state_q == StDone);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
module tb_adc_scan_sequencer;

    localparam int unsigned NCH     = 4;
    localparam int unsigned DW      = 16;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned PERIOD  = 200;
    localparam int unsigned TMO     = 50;
    localparam int unsigned ADC_LAT = 10;

    logic          clk = 1'b0;
    logic          reset, enable, single_shot, adc_done, err_clr;
    logic [3:0]    ch_mask;
    logic [1:0]    mux_sel, rd_ch;
    logic          adc_start, rd_valid, busy, scan_done, timeout_err;
    logic [DW-1:0] adc_data, rd_data;

    always #5 clk = ~clk;

    adc_scan_sequencer #(
        .NUM_CH       (NCH),
        .DATA_W       (DW),
        .SETTLE_CYC   (SETTLE),
        .SCAN_PERIOD  (PERIOD),
        .CONV_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .single_shot (single_shot),
        .ch_mask     (ch_mask),
        .mux_sel     (mux_sel),
        .adc_start   (adc_start),
        .adc_done    (adc_done),
        .adc_data    (adc_data),
        .rd_ch       (rd_ch),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .scan_done   (scan_done),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ADC model and observation log
    logic [3:0] silent;
    int         adc_pend;
    logic [1:0] adc_ch;
    int         cyc;
    logic [1:0] last_mux;
    bit         mux_chg;
    int         mux_chg_cyc;
    int         start_ch[$];
    int         start_cyc[$];
    int         gaps[$];
    int         done_cnt;
    int         busy_cnt;
    bit         err_seen;
    int         err_cyc;

    // Expected result store, updated from channel/silence rules only
    logic [DW-1:0] exp_val [NCH];
    bit            exp_vld [NCH];

    task automatic tick();
        @(negedge clk);
        cyc++;
        adc_done = 1'b0;
        if (adc_pend > 0) begin
            adc_pend--;
            if (adc_pend == 0) begin
                adc_done = 1'b1;
                adc_data = 16'h1000 + 16'(adc_ch);
            end
        end
        if (adc_start === 1'b1 && !silent[mux_sel]) begin
            adc_pend = ADC_LAT;
            adc_ch   = mux_sel;
        end
        if (mux_sel !== last_mux) begin
            last_mux    = mux_sel;
            mux_chg     = 1'b1;
            mux_chg_cyc = cyc;
        end
        if (adc_start === 1'b1) begin
            start_ch.push_back(int'(mux_sel));
            start_cyc.push_back(cyc);
            if (mux_chg) gaps.push_back(cyc - mux_chg_cyc);
            mux_chg = 1'b0;
        end
        if (scan_done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (timeout_err === 1'b1 && !err_seen) begin
            err_seen = 1'b1;
            err_cyc  = cyc;
        end
    endtask

    task automatic clear_log();
        start_ch.delete();
        start_cyc.delete();
        gaps.delete();
        done_cnt = 0;
        busy_cnt = 0;
        err_seen = 1'b0;
        mux_chg  = 1'b0;
        last_mux = mux_sel;
    endtask

    task automatic clear_model();
        for (int c = 0; c < NCH; c++) begin
            exp_val[c] = '0;
            exp_vld[c] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        clear_model();
        clear_log();
    endtask

    // A completed scan stores every enabled, answering channel.
    task automatic model_scan(input logic [3:0] mask);
        for (int c = 0; c < NCH; c++) begin
            if (mask[c] && !silent[c]) begin
                exp_val[c] = 16'h1000 + 16'(c);
                exp_vld[c] = 1'b1;
            end
        end
    endtask

    task automatic check_starts(input string tag, input logic [3:0] mask);
        int k;
        int n;
        k = 0;
        n = 0;
        for (int c = 0; c < NCH; c++) if (mask[c]) n++;
        check_eq({tag, "_nstarts"}, start_ch.size(), n);
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                if (k < start_ch.size()) check_eq({tag, "_chan"}, start_ch[k], c);
                k++;
            end
        end
        foreach (gaps[i]) check_eq({tag, "_settle"}, gaps[i], SETTLE);
    endtask

    task automatic check_regs(input string tag);
        for (int c = 0; c < NCH; c++) begin
            rd_ch = 2'(c);
            tick();
            check_eq({tag, "_rd_data"}, rd_data, exp_val[c]);
            check_eq({tag, "_rd_valid"}, rd_valid, exp_vld[c]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_mux_sel"}, mux_sel, 0);
        check_eq({tag, "_adc_start"}, adc_start, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_scan_done"}, scan_done, 0);
        check_eq({tag, "_timeout_err"}, timeout_err, 0);
        check_eq({tag, "_rd_data"}, rd_data, 0);
        check_eq({tag, "_rd_valid"}, rd_valid, 0);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) tick();
    endtask

    // One single-shot scan; ch_mask is scrambled right after the start to
    // show that the latched mask governs the scan.
    task automatic single_scan(input string tag, input logic [3:0] mask);
        clear_log();
        ch_mask     = mask;
        single_shot = 1'b1;
        tick();
        single_shot = 1'b0;
        ch_mask     = 4'($urandom_range(0, 15));
        wait_done(1, 1500);
        repeat (3) tick();
        ch_mask = 4'h0;
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_busy_after"}, busy, 0);
        check_starts(tag, mask);
        model_scan(mask);
    endtask

    initial begin
        logic [3:0] m;
        logic [3:0] s;
        reset       = 1'b1;
        enable      = 1'b0;
        single_shot = 1'b0;
        ch_mask     = 4'h0;
        adc_done    = 1'b0;
        adc_data    = '0;
        rd_ch       = 2'd0;
        err_clr     = 1'b0;
        silent      = 4'h0;
        adc_pend    = 0;
        adc_ch      = 2'd0;
        cyc         = 0;
        err_cyc     = 0;
        mux_chg_cyc = 0;
        clear_model();
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();
        clear_log();

        // Single scan over channels 0,1,3
        single_scan("scan1011", 4'b1011);
        check_eq("scan1011_gaps", gaps.size(), 2);
        check_regs("scan1011");

        // Continuous single channel: one conversion per period
        clear_log();
        ch_mask = 4'b0001;
        enable  = 1'b1;
        for (int i = 0; i < 1000 && start_cyc.size() < 3; i++) tick();
        check_eq("period_nstarts", start_cyc.size(), 3);
        if (start_cyc.size() >= 3) begin
            check_eq("period_gap1", start_cyc[1] - start_cyc[0], PERIOD);
            check_eq("period_gap2", start_cyc[2] - start_cyc[1], PERIOD);
        end
        enable = 1'b0;
        repeat (300) tick();
        check_eq("period_stopped", start_cyc.size(), 3);
        check_eq("period_busy", busy, 0);
        model_scan(4'b0001);
        check_regs("period");

        // Empty mask never starts
        clear_log();
        ch_mask = 4'h0;
        enable  = 1'b1;
        repeat (1000) tick();
        check_eq("nomask_starts", start_ch.size(), 0);
        check_eq("nomask_done", done_cnt, 0);
        check_eq("nomask_busy", busy_cnt, 0);
        enable = 1'b0;
        tick();

        // Silent channel 1 times out, scan continues
        do_reset();
        silent = 4'b0010;
        single_scan("tmo", 4'b0111);
        check_eq("tmo_err", timeout_err, 1);
        if (start_cyc.size() >= 2) check_eq("tmo_latency", err_cyc - start_cyc[1], TMO);
        check_regs("tmo");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("tmo_clr", timeout_err, 0);
        silent = 4'h0;

        // Enable dropped during channel 1 settle
        do_reset();
        ch_mask = 4'b0111;
        enable  = 1'b1;
        for (int i = 0; i < 300 && !(mux_sel == 2'd1 && busy); i++) tick();
        enable = 1'b0;
        wait_done(1, 600);
        repeat (3) tick();
        ch_mask = 4'h0;
        check_eq("drop_done_cnt", done_cnt, 1);
        check_eq("drop_busy", busy, 0);
        check_starts("drop", 4'b0011);
        model_scan(4'b0011);
        check_regs("drop");

        // Reset while converting; the late adc_done must be ignored
        do_reset();
        rd_ch       = 2'd0;
        ch_mask     = 4'b0001;
        single_shot = 1'b1;
        tick();
        single_shot = 1'b0;
        ch_mask     = 4'h0;
        for (int i = 0; i < 100 && start_ch.size() < 1; i++) tick();
        check_eq("rstconv_started", start_ch.size(), 1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("rstconv");
        reset = 1'b0;
        clear_model();
        clear_log();
        repeat (20) tick();
        check_eq("rstconv_busy", busy_cnt, 0);
        check_eq("rstconv_done", done_cnt, 0);
        check_regs("rstconv");

        // Randomized single scans with occasional silent channels
        for (int it = 0; it < 8; it++) begin
            m      = 4'($urandom_range(1, 15));
            s      = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            silent = s;
            single_scan("rnd", m);
            check_eq("rnd_err", timeout_err, ((m & s) != 4'h0) ? 1 : 0);
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            check_eq("rnd_err_clr", timeout_err, 0);
            check_regs("rnd");
        end
        silent = 4'h0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
